// File: rtl/flash_byte_responder.sv
// SPI mode-0 single-byte READ (0x03) responder between the CPU fetch handshake and the external flash.
// Define FLASH_WAKEUP_EN to send a release-power-down (0xAB) and wait WAKE_WAIT cycles after reset.
module flash_byte_responder #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned WAKE_WAIT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] flashReadAddr,
  input  logic        enableFlash,
  output logic [7:0]  flashByteRead,
  output logic        flashDataReady,
  output logic        flashClk,
  output logic        flashCs,
  output logic        flashMosi,
  input  logic        flashMiso,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_INIT         = 3'd0,
    ST_IDLE         = 3'd1,
    ST_SHIFT        = 3'd2,
    ST_DONE         = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [5:0]  LAST_BIT = 6'd39;

  if (CLK_DIV < 1 || WAKE_WAIT > 32'h00FF_FFFF) begin : g_bad_param
    $error("flash_byte_responder: CLK_DIV must be >= 1 and WAKE_WAIT must fit in 24 bits");
  end

  state_t      state_q, state_d;
  logic [30:0] sr_q, sr_d;
  logic [7:0]  cap_q, cap_d;
  logic [15:0] div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  byte_q, byte_d;
  logic        ready_q, ready_d;
`ifdef FLASH_WAKEUP_EN
  localparam logic [23:0] WAIT_LAST = 24'(WAKE_WAIT - 1);
  logic [1:0]  init_ph_q, init_ph_d;
  logic [23:0] wait_q, wait_d;
`endif

  logic        tick, rise, fall, sck_run;
  logic [23:0] addr24;
  logic [31:0] cmd_word;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cap_d   = cap_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    byte_d  = byte_q;
    ready_d = ready_q;
`ifdef FLASH_WAKEUP_EN
    init_ph_d = init_ph_q;
    wait_d    = wait_q;
    sck_run   = (state_q == ST_SHIFT) || (state_q == ST_INIT && init_ph_q == 2'd1);
`else
    sck_run   = (state_q == ST_SHIFT);
`endif
    tick     = (div_q == DIV_LAST);
    rise     = tick && !sck_q;
    fall     = tick && sck_q;
    addr24   = BASE_ADDR + {13'd0, flashReadAddr};
    cmd_word = {8'h03, addr24};

    // Shared SCK generator: CLK_DIV cycles low, then CLK_DIV cycles high.
    if (sck_run) begin
      if (tick) begin
        div_d = 16'd0;
        sck_d = !sck_q;
      end else begin
        div_d = div_q + 16'd1;
      end
    end

    case (state_q)
`ifdef FLASH_WAKEUP_EN
      ST_INIT: begin
        case (init_ph_q)
          2'd0: begin
            cs_d      = 1'b0;
            mosi_d    = 1'b1;
            sr_d      = {7'h2B, 24'd0};
            sck_d     = 1'b0;
            div_d     = 16'd0;
            bit_d     = 6'd0;
            init_ph_d = 2'd1;
          end
          2'd1: begin
            if (fall) begin
              if (bit_q == 6'd7) begin
                cs_d      = 1'b1;
                mosi_d    = 1'b0;
                wait_d    = 24'd0;
                init_ph_d = 2'd2;
              end else begin
                bit_d  = bit_q + 6'd1;
                mosi_d = sr_q[30];
                sr_d   = {sr_q[29:0], 1'b0};
              end
            end
          end
          default: begin
            if (wait_q == WAIT_LAST) begin
              state_d = ST_IDLE;
            end else begin
              wait_d = wait_q + 24'd1;
            end
          end
        endcase
      end
`endif
      ST_IDLE: begin
        if (enableFlash) begin
          mosi_d  = cmd_word[31];
          sr_d    = cmd_word[30:0];
          cap_d   = 8'd0;
          sck_d   = 1'b0;
          div_d   = 16'd0;
          bit_d   = 6'd0;
          cs_d    = 1'b0;
          ready_d = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rise && bit_q >= 6'd32) begin
          cap_d = {cap_q[6:0], flashMiso};
        end
        if (fall) begin
          if (bit_q == LAST_BIT) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            byte_d  = cap_q;
            ready_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Command/address bits end at bit 31; MOSI idles low for the data byte.
            bit_d  = bit_q + 6'd1;
            mosi_d = (bit_q < 6'd31) ? sr_q[30] : 1'b0;
            sr_d   = {sr_q[29:0], 1'b0};
          end
        end
      end
      ST_DONE: begin
        state_d = enableFlash ? ST_WAIT_RELEASE : ST_IDLE;
      end
      ST_WAIT_RELEASE: begin
        if (!enableFlash) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef FLASH_WAKEUP_EN
      state_q   <= ST_INIT;
      init_ph_q <= 2'd0;
      wait_q    <= 24'd0;
`else
      state_q   <= ST_IDLE;
`endif
      sr_q    <= 31'd0;
      cap_q   <= 8'd0;
      div_q   <= 16'd0;
      bit_q   <= 6'd0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      byte_q  <= 8'd0;
      ready_q <= 1'b1;
    end else begin
`ifdef FLASH_WAKEUP_EN
      init_ph_q <= init_ph_d;
      wait_q    <= wait_d;
`endif
      state_q <= state_d;
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      byte_q  <= byte_d;
      ready_q <= ready_d;
    end
  end

  assign flashByteRead  = byte_q;
  assign flashDataReady = ready_q;
  assign flashClk       = sck_q;
  assign flashCs        = cs_q;
  assign flashMosi      = mosi_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_flash_byte_responder.sv
// Directed bench for flash_byte_responder with a behavioural SPI flash model.
// BASE_ADDR is 24'hFFFFF0 so that request address 0x020 lands on flash byte 0x000010.
module tb_flash_byte_responder;

  localparam logic [23:0] BASE      = 24'hFFFFF0;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned WAKE_WAIT = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] flashReadAddr = 11'd0;
  logic        enableFlash = 1'b0;
  logic [7:0]  flashByteRead;
  logic        flashDataReady;
  logic        flashClk;
  logic        flashCs;
  logic        flashMosi;
  logic        flashMiso = 1'b0;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  flash_byte_responder #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (CLK_DIV),
    .WAKE_WAIT (WAKE_WAIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flashReadAddr  (flashReadAddr),
    .enableFlash    (enableFlash),
    .flashByteRead  (flashByteRead),
    .flashDataReady (flashDataReady),
    .flashClk       (flashClk),
    .flashCs        (flashCs),
    .flashMosi      (flashMosi),
    .flashMiso      (flashMiso),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // Flash contents: one fixed test byte, everything else a simple address hash.
  function automatic logic [7:0] flash_mem(input logic [23:0] a);
    if (a == 24'h000010) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // SPI flash model: samples MOSI on SCK rise, drives MISO after SCK fall.
  int          rise_cnt = 0;
  int          cs_falls = 0;
  int          mosi_err = 0;
  logic [31:0] rx_word = 32'd0;
  logic [7:0]  tx_byte = 8'd0;
  logic        prev_clk = 1'b0;
  logic        prev_cs  = 1'b1;

  always @(flashClk or flashCs) begin
    if (prev_cs === 1'b1 && flashCs === 1'b0) begin
      rise_cnt = 0;
      cs_falls++;
    end else if (prev_clk === 1'b0 && flashClk === 1'b1 && flashCs === 1'b0) begin
      if (rise_cnt < 32) rx_word = {rx_word[30:0], flashMosi};
      else if (flashMosi !== 1'b0) mosi_err++;
      rise_cnt++;
      if (rise_cnt == 32) tx_byte = flash_mem(rx_word[23:0]);
    end else if (prev_clk === 1'b1 && flashClk === 1'b0 && flashCs === 1'b0) begin
      if (rise_cnt >= 32 && rise_cnt < 40) flashMiso = tx_byte[39 - rise_cnt];
    end
    prev_clk = flashClk;
    prev_cs  = flashCs;
  end

  task automatic wait_idle();
    int n = 0;
    while (dbg_state !== 3'd1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state !== 3'd1) begin
      errors++;
      $display("FAIL wait_idle: state=%0d required 1 after %0d cycles", dbg_state, n);
    end
  endtask

  // Call at a negedge; returns at the negedge after the completion edge, enable still high.
  task automatic run_read(input logic [10:0] addr, input logic [23:0] exp_addr,
                          input logic [7:0] exp_byte, input string name);
    int cyc = 0;
    enableFlash   = 1'b1;
    flashReadAddr = addr;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (flashDataReady !== 1'b0 || flashCs !== 1'b0) begin
      errors++;
      $display("FAIL %s start: ready=%b cs=%b required 0/0", name, flashDataReady, flashCs);
    end
    while (flashDataReady !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 160) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required 160", name, cyc);
    end
    checks++;
    if (flashByteRead !== exp_byte) begin
      errors++;
      $display("FAIL %s data: got %h required %h", name, flashByteRead, exp_byte);
    end
    checks++;
    if (rx_word !== {8'h03, exp_addr}) begin
      errors++;
      $display("FAIL %s command: got %h required %h", name, rx_word, {8'h03, exp_addr});
    end
    checks++;
    if (rise_cnt != 40 || flashCs !== 1'b1 || flashClk !== 1'b0) begin
      errors++;
      $display("FAIL %s frame: sck rises=%0d cs=%b sck=%b required 40/1/0", name, rise_cnt, flashCs, flashClk);
    end
    checks++;
    if (mosi_err != 0) begin
      errors++;
      $display("FAIL %s mosi_data_phase: got %0d nonzero bits required 0", name, mosi_err);
    end
  endtask

  task automatic test_reset();
    enableFlash = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (flashCs !== 1'b1 || flashClk !== 1'b0 || flashMosi !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: cs=%b sck=%b mosi=%b required 1/0/0", flashCs, flashClk, flashMosi);
    end
    checks++;
    if (flashByteRead !== 8'h00 || flashDataReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_result: byte=%h ready=%b required 00/1", flashByteRead, flashDataReady);
    end
    checks++;
`ifdef FLASH_WAKEUP_EN
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
`else
    if (dbg_state !== 3'd1) begin
      errors++;
      $display("FAIL reset_state: got %0d required 1", dbg_state);
    end
`endif
    reset = 1'b0;
    wait_idle();
  endtask

`ifdef FLASH_WAKEUP_EN
  task automatic test_wakeup();
    int n = 0;
    int hi = 0;
    int f0;
    enableFlash   = 1'b1;
    flashReadAddr = 11'h020;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    f0 = cs_falls;
    reset = 1'b0;
    while (!(cs_falls > f0 && flashCs === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rise_cnt != 8 || rx_word[7:0] !== 8'hAB) begin
      errors++;
      $display("FAIL wakeup_cmd: rises=%0d byte=%h required 8/ab", rise_cnt, rx_word[7:0]);
    end
    while (flashCs === 1'b1 && hi < 2000) begin
      @(negedge clk);
      hi++;
    end
    checks++;
    if (hi < int'(WAKE_WAIT) || hi > int'(WAKE_WAIT) + 2) begin
      errors++;
      $display("FAIL wakeup_gap: cs high %0d cycles required %0d..%0d", hi, WAKE_WAIT, WAKE_WAIT + 2);
    end
    n = 0;
    while (flashDataReady !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (flashByteRead !== 8'h5A || rx_word !== 32'h03000010) begin
      errors++;
      $display("FAIL wakeup_read: byte=%h cmd=%h required 5a/03000010", flashByteRead, rx_word);
    end
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_addr_patterns();
    @(negedge clk);
    run_read(11'h020, 24'h000010, 8'h5A, "read_0x020");
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
    run_read(11'h00F, 24'hFFFFFF, 8'h3C, "read_0x00f");
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
    run_read(11'h7FF, 24'h0007EF, 8'hD4, "read_0x7ff_wrap");
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
    run_read(11'h000, 24'hFFFFF0, 8'h33, "read_0x000");
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold_enable();
    int f0;
    int bad = 0;
    @(negedge clk);
    f0 = cs_falls;
    run_read(11'h100, 24'h0000F0, 8'hCC, "hold_first");
    repeat (500) begin
      @(negedge clk);
      if (flashDataReady !== 1'b1 || flashByteRead !== 8'hCC) bad++;
    end
    checks++;
    if (cs_falls - f0 != 1) begin
      errors++;
      $display("FAIL hold_single_txn: cs-low periods=%0d required 1", cs_falls - f0);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
    end
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
    run_read(11'h00F, 24'hFFFFFF, 8'h3C, "hold_second");
    checks++;
    if (cs_falls - f0 != 2) begin
      errors++;
      $display("FAIL hold_rearm: cs-low periods=%0d required 2", cs_falls - f0);
    end
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_read(11'h020, 24'h000010, 8'h5A, "b2b_first");
    enableFlash = 1'b0;
    @(negedge clk);
    checks++;
    if (flashCs !== 1'b1 || flashDataReady !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: cs=%b ready=%b required 1/1", flashCs, flashDataReady);
    end
    run_read(11'h030, 24'h000020, 8'h1C, "b2b_second");
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    enableFlash   = 1'b1;
    flashReadAddr = 11'h7FF;
    @(posedge clk);
    @(negedge clk);
    while (rise_cnt < 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rise_cnt != 20) begin
      errors++;
      $display("FAIL mid_reach_bit20: rises=%0d required 20", rise_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (flashCs !== 1'b1 || flashClk !== 1'b0 || flashMosi !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pins: cs=%b sck=%b mosi=%b required 1/0/0", flashCs, flashClk, flashMosi);
    end
    checks++;
    if (flashDataReady !== 1'b1 || flashByteRead !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_result: ready=%b byte=%h required 1/00", flashDataReady, flashByteRead);
    end
    reset = 1'b0;
    enableFlash = 1'b0;
    wait_idle();
    @(negedge clk);
    run_read(11'h7FF, 24'h0007EF, 8'hD4, "after_reset");
    enableFlash = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_addr_change();
    int cyc = 0;
    @(negedge clk);
    enableFlash   = 1'b1;
    flashReadAddr = 11'h000;
    @(posedge clk);
    @(negedge clk);
    repeat (30) begin
      @(negedge clk);
      cyc++;
    end
    flashReadAddr = 11'h7FF;
    enableFlash   = 1'b0;
    while (flashDataReady !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 160 || rise_cnt != 40) begin
      errors++;
      $display("FAIL change_complete: cycles=%0d rises=%0d required 160/40", cyc, rise_cnt);
    end
    checks++;
    if (rx_word !== 32'h03FFFFF0) begin
      errors++;
      $display("FAIL change_latched_addr: got %h required 03fffff0", rx_word);
    end
    checks++;
    if (flashByteRead !== 8'h33) begin
      errors++;
      $display("FAIL change_data: got %h required 33", flashByteRead);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
`ifdef FLASH_WAKEUP_EN
    test_wakeup();
`endif
    test_addr_patterns();
    test_hold_enable();
    test_back_to_back();
    test_reset_mid();
    test_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
